// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  // Access sequencer states: sample, command strobe, latency wait, acknowledge.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Which requester owns the access currently in flight.
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  // Default geometry and timing.
  localparam int DEF_ADDR_W     = 10;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_MEM_LAT    = 1;
  localparam int DEF_STARVE_MAX = 4;

  // Counter width able to hold 0..max_val, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and data requests, with a saturating
// counter that bounds how many data grants fetch can be passed over for.
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic if_req_i,
  input  logic dm_req_i,
  input  logic grant_i,
  output logic pick_if_o
);

  localparam int SC_W = cnt_width(STARVE_MAX);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_MAX);

  logic [SC_W-1:0] starve_q;
  logic [SC_W-1:0] starve_d;

  // Data wins by default; fetch wins when alone or once it has waited long enough.
  assign pick_if_o = if_req_i & (~dm_req_i | (starve_q == SC_MAX));

  // Count data grants that happen while fetch is waiting, clear otherwise.
  always_comb begin
    starve_d = starve_q;
    if (grant_i) begin
      if (pick_if_o || !if_req_i) begin
        starve_d = '0;
      end else if (starve_q != SC_MAX) begin
        starve_d = starve_q + SC_W'(1);
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serializes instruction-fetch and data accesses onto one single-ported
// synchronous memory: IDLE samples, CMD strobes the memory, WAIT covers the
// read latency, RESP pulses the owner's ack.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // WAIT occupies MEM_LAT cycles; the last one (count 0) is when the memory
  // presents read data, which lands the ack exactly MEM_LAT+1 cycles after CMD.
  localparam int WC_W = cnt_width(MEM_LAT - 1);
  localparam logic [WC_W-1:0] WC_LOAD = WC_W'(MEM_LAT - 1);

  state_t            state_q,     state_d;
  logic [WC_W-1:0]   wcnt_q,      wcnt_d;
  logic              owner_q,     owner_d;
  logic              cmd_we_q,    cmd_we_d;
  logic              mem_en_q,    mem_en_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q,    if_ack_d;
  logic              dm_ack_q,    dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;

  logic grant;
  logic pick_if;

  assign grant = (state_q == ST_IDLE) & (if_req | dm_req);

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk_i     (clk),
    .rst_i     (rst),
    .if_req_i  (if_req),
    .dm_req_i  (dm_req),
    .grant_i   (grant),
    .pick_if_o (pick_if)
  );

  // Sequencer next state, command latch and response capture.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    owner_d     = owner_q;
    cmd_we_d    = cmd_we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d  = ST_CMD;
          mem_en_d = 1'b1;
          if (pick_if) begin
            // Fetch is read-only; the write-data register is left as is.
            owner_d    = OWN_IF;
            cmd_we_d   = 1'b0;
            mem_addr_d = if_addr;
          end else begin
            owner_d     = OWN_DM;
            cmd_we_d    = dm_we;
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
          end
        end
      end
      ST_CMD: begin
        state_d = ST_WAIT;
        wcnt_d  = WC_LOAD;
      end
      ST_WAIT: begin
        if (wcnt_q == '0) begin
          state_d = ST_RESP;
          if (owner_q == OWN_IF) begin
            if_ack_d = 1'b1;
            if (!cmd_we_q) if_rdata_d = mem_rdata;
          end else begin
            dm_ack_d = 1'b1;
            if (!cmd_we_q) dm_rdata_d = mem_rdata;
          end
        end else begin
          wcnt_d = wcnt_q - WC_W'(1);
        end
      end
      ST_RESP: begin
        // Requests are not sampled here; a still-pending one is taken next cycle.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All state and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wcnt_q      <= '0;
      owner_q     <= OWN_DM;
      cmd_we_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      owner_q     <= owner_d;
      cmd_we_q    <= cmd_we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

  // Stalls follow the request combinationally so the pipeline freezes at once.
  assign if_stall = if_req & ~if_ack_q;
  assign dm_stall = dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT 1 and 3) share one
// transaction-level reference model and a memory model that drives junk on
// mem_rdata outside the cycle where read data is due.
module tb_mem_arbiter;

  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int SMAX = 4;
  localparam int NI   = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req    [NI];
  logic [AW-1:0] if_addr   [NI];
  logic          if_ack    [NI];
  logic [DW-1:0] if_rdata  [NI];
  logic          if_stall  [NI];
  logic          dm_req    [NI];
  logic          dm_we     [NI];
  logic [AW-1:0] dm_addr   [NI];
  logic [DW-1:0] dm_wdata  [NI];
  logic          dm_ack    [NI];
  logic [DW-1:0] dm_rdata  [NI];
  logic          dm_stall  [NI];
  logic          mem_en    [NI];
  logic          mem_we    [NI];
  logic [AW-1:0] mem_addr  [NI];
  logic [DW-1:0] mem_wdata [NI];
  logic [DW-1:0] mem_rdata [NI] = '{32'h0, 32'h0};

  int errors = 0;
  int checks = 0;
  bit rand_mode = 1'b0;

  logic [DW-1:0] env_mem [NI][1024];
  logic [DW-1:0] ref_mem [NI][1024];

  // reference model state: m_t = cycles since the access was sampled (0 = idle)
  int            m_t      [NI];
  int            m_starve [NI];
  bit            m_own_if [NI];
  bit            m_we     [NI];
  logic [AW-1:0] m_addr   [NI];
  logic [DW-1:0] m_wdata  [NI];
  logic [DW-1:0] e_if_rd  [NI];
  logic [DW-1:0] e_dm_rd  [NI];

  int            cyc = 0;
  int            cap_cyc  [NI] = '{-1, -1};
  logic [AW-1:0] cap_addr [NI];

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_MAX(SMAX)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_ack(if_ack[0]),
    .if_rdata(if_rdata[0]), .if_stall(if_stall[0]),
    .dm_req(dm_req[0]), .dm_we(dm_we[0]), .dm_addr(dm_addr[0]), .dm_wdata(dm_wdata[0]),
    .dm_ack(dm_ack[0]), .dm_rdata(dm_rdata[0]), .dm_stall(dm_stall[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .STARVE_MAX(SMAX)) u_dut_l3 (
    .clk(clk), .rst(rst),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_ack(if_ack[1]),
    .if_rdata(if_rdata[1]), .if_stall(if_stall[1]),
    .dm_req(dm_req[1]), .dm_we(dm_we[1]), .dm_addr(dm_addr[1]), .dm_wdata(dm_wdata[1]),
    .dm_ack(dm_ack[1]), .dm_rdata(dm_rdata[1]), .dm_stall(dm_stall[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset(input int i);
    m_t[i]      = 0;
    m_starve[i] = 0;
    m_own_if[i] = 1'b0;
    m_we[i]     = 1'b0;
    m_addr[i]   = '0;
    m_wdata[i]  = '0;
    e_if_rd[i]  = '0;
    e_dm_rd[i]  = '0;
  endtask

  // one clock of the reference model, using the inputs sampled at the edge
  task automatic model_advance(input int i);
    int L;
    bit fw;
    L = lat(i);
    if (rst) begin
      model_reset(i);
      return;
    end
    if (m_t[i] == 0) begin
      if (if_req[i] || dm_req[i]) begin
        fw = if_req[i] && (!dm_req[i] || m_starve[i] == SMAX);
        if (fw || !if_req[i]) m_starve[i] = 0;
        else if (m_starve[i] < SMAX) m_starve[i] = m_starve[i] + 1;
        m_own_if[i] = fw;
        m_addr[i]   = fw ? if_addr[i] : dm_addr[i];
        m_we[i]     = fw ? 1'b0 : dm_we[i];
        if (!fw) m_wdata[i] = dm_wdata[i];
        m_t[i] = 1;
      end
    end else begin
      if (m_t[i] == 1 && m_we[i]) ref_mem[i][m_addr[i]] = m_wdata[i];
      if (m_t[i] == 1 + L && !m_we[i]) begin
        if (m_own_if[i]) e_if_rd[i] = ref_mem[i][m_addr[i]];
        else             e_dm_rd[i] = ref_mem[i][m_addr[i]];
      end
      m_t[i] = (m_t[i] == 2 + L) ? 0 : m_t[i] + 1;
    end
  endtask

  task automatic check_outputs(input int i);
    int   L;
    logic e_en, e_ifa, e_dma;
    L = lat(i);
    if (rst) model_reset(i);
    e_en  = (m_t[i] == 1);
    e_ifa = (m_t[i] == 2 + L) &&  m_own_if[i];
    e_dma = (m_t[i] == 2 + L) && !m_own_if[i];
    chk($sformatf("mem_en[%0d]", i),    mem_en[i],    e_en);
    chk($sformatf("mem_we[%0d]", i),    mem_we[i],    e_en & m_we[i]);
    chk($sformatf("mem_addr[%0d]", i),  mem_addr[i],  m_addr[i]);
    chk($sformatf("mem_wdata[%0d]", i), mem_wdata[i], m_wdata[i]);
    chk($sformatf("if_ack[%0d]", i),    if_ack[i],    e_ifa);
    chk($sformatf("dm_ack[%0d]", i),    dm_ack[i],    e_dma);
    chk($sformatf("if_rdata[%0d]", i),  if_rdata[i],  e_if_rd[i]);
    chk($sformatf("dm_rdata[%0d]", i),  dm_rdata[i],  e_dm_rd[i]);
    chk($sformatf("if_stall[%0d]", i),  if_stall[i],  if_req[i] & ~e_ifa);
    chk($sformatf("dm_stall[%0d]", i),  dm_stall[i],  dm_req[i] & ~e_dma);
    chk($sformatf("ack_excl[%0d]", i),  if_ack[i] & dm_ack[i], 1'b0);
  endtask

  task automatic drive_random(input int i);
    if (if_ack[i] || !if_req[i]) begin
      if_req[i]  = ($urandom_range(0, 3) != 0);
      if_addr[i] = AW'($urandom_range(0, 31));
    end else if ($urandom_range(0, 15) == 0) begin
      if_req[i] = 1'b0;
    end
    if ($urandom_range(0, 7) == 0) if_addr[i] = AW'($urandom_range(0, 31));
    if (dm_ack[i] || !dm_req[i]) begin
      dm_req[i]   = ($urandom_range(0, 2) != 0);
      dm_we[i]    = $urandom_range(0, 1) == 1;
      dm_addr[i]  = AW'($urandom_range(0, 31));
      dm_wdata[i] = $urandom;
    end else if ($urandom_range(0, 15) == 0) begin
      dm_req[i] = 1'b0;
    end
    if ($urandom_range(0, 7) == 0) dm_wdata[i] = $urandom;
  endtask

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NI; i++) check_outputs(i);
    if (rand_mode) for (int i = 0; i < NI; i++) drive_random(i);
  endtask

  task automatic wait_ack(input int i, input bit want_if, output int n);
    bit got;
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      tick();
      n++;
      got = want_if ? if_ack[i] : dm_ack[i];
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout[%0d]: got no ack expected ack within 40 cycles", i);
    end
  endtask

  // memory model and reference-model clocking
  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < NI; i++) model_advance(i);
      #1;
      cyc++;
      for (int i = 0; i < NI; i++) begin
        if (mem_en[i]) begin
          if (mem_we[i]) env_mem[i][mem_addr[i]] = mem_wdata[i];
          else begin
            cap_cyc[i]  = cyc + lat(i);
            cap_addr[i] = mem_addr[i];
          end
        end
        if (cyc == cap_cyc[i]) mem_rdata[i] = env_mem[i][cap_addr[i]];
        else                   mem_rdata[i] = $urandom;
      end
    end
  end

  initial begin
    int n;
    int grants [NI];
    logic [DW-1:0] v;
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      if_req[i] = 1'b0; if_addr[i] = '0;
      dm_req[i] = 1'b0; dm_we[i] = 1'b0; dm_addr[i] = '0; dm_wdata[i] = '0;
      for (int a = 0; a < 1024; a++) begin
        v = $urandom;
        env_mem[i][a] = v;
        ref_mem[i][a] = v;
      end
      env_mem[i][4] = 32'h8C010000;
      ref_mem[i][4] = 32'h8C010000;
    end
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < NI; i++) begin
      // single fetch
      if_req[i]  = 1'b1;
      if_addr[i] = 10'h004;
      tick();
      chk($sformatf("fetch_cmd_en[%0d]", i), mem_en[i], 1'b1);
      chk($sformatf("fetch_cmd_addr[%0d]", i), mem_addr[i], 10'h004);
      wait_ack(i, 1'b1, n);
      chk($sformatf("fetch_ack_lat[%0d]", i), n + 1, 2 + lat(i));
      chk($sformatf("fetch_rdata[%0d]", i), if_rdata[i], 32'h8C010000);
      if_req[i] = 1'b0;
      tick();

      // store then load of the same word
      dm_req[i]   = 1'b1;
      dm_we[i]    = 1'b1;
      dm_addr[i]  = 10'h010;
      dm_wdata[i] = 32'hDEADBEEF;
      wait_ack(i, 1'b0, n);
      chk($sformatf("store_ack_lat[%0d]", i), n, 2 + lat(i));
      dm_we[i]    = 1'b0;
      dm_wdata[i] = 32'h12345678;
      wait_ack(i, 1'b0, n);
      chk($sformatf("ack_spacing[%0d]", i), n, 3 + lat(i));
      chk($sformatf("load_data[%0d]", i), dm_rdata[i], 32'hDEADBEEF);
      dm_req[i] = 1'b0;
      tick();

      // simultaneous requests: data first, then fetch
      if_req[i]  = 1'b1; if_addr[i] = 10'h020;
      dm_req[i]  = 1'b1; dm_addr[i] = 10'h021; dm_we[i] = 1'b0;
      wait_ack(i, 1'b0, n);
      chk($sformatf("conflict_dm_ack[%0d]", i), n, 2 + lat(i));
      dm_req[i] = 1'b0;
      wait_ack(i, 1'b1, n);
      chk($sformatf("conflict_if_ack[%0d]", i), n, 3 + lat(i));
      if_req[i] = 1'b0;
      tick();
    end

    // starvation bound with both requests held high
    for (int i = 0; i < NI; i++) begin
      if_req[i] = 1'b1; if_addr[i] = 10'h100;
      dm_req[i] = 1'b1; dm_addr[i] = 10'h200; dm_we[i] = 1'b0;
      grants[i] = 0;
    end
    repeat (70) begin
      tick();
      for (int i = 0; i < NI; i++) begin
        if (mem_en[i]) begin
          chk($sformatf("starve_pick[%0d] g%0d", i, grants[i]),
              mem_addr[i] == if_addr[i], (grants[i] % 5) == 4);
          grants[i]++;
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("starve_grants[%0d]", i), grants[i] >= 10, 1'b1);
      if_req[i] = 1'b0;
      dm_req[i] = 1'b0;
    end
    repeat (8) tick();

    // randomized traffic
    rand_mode = 1'b1;
    repeat (1500) tick();
    rand_mode = 1'b0;
    for (int i = 0; i < NI; i++) begin
      if_req[i] = 1'b0;
      dm_req[i] = 1'b0;
    end
    repeat (10) tick();

    // reset while a read sits in WAIT
    for (int i = 0; i < NI; i++) begin
      dm_req[i] = 1'b1; dm_we[i] = 1'b0; dm_addr[i] = 10'h005;
    end
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < NI; i++) dm_req[i] = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_mem_en[%0d]", i),    mem_en[i],    1'b0);
      chk($sformatf("rst_mem_we[%0d]", i),    mem_we[i],    1'b0);
      chk($sformatf("rst_mem_addr[%0d]", i),  mem_addr[i],  '0);
      chk($sformatf("rst_mem_wdata[%0d]", i), mem_wdata[i], '0);
      chk($sformatf("rst_if_ack[%0d]", i),    if_ack[i],    1'b0);
      chk($sformatf("rst_dm_ack[%0d]", i),    dm_ack[i],    1'b0);
      chk($sformatf("rst_if_rdata[%0d]", i),  if_rdata[i],  '0);
      chk($sformatf("rst_dm_rdata[%0d]", i),  dm_rdata[i],  '0);
      chk($sformatf("rst_dm_stall[%0d]", i),  dm_stall[i],  1'b0);
    end
    tick();
    tick();
    rst = 1'b0;
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
